// File: rtl/maze_map.sv
// maze_map: 16x16 wall/visited map with row loading, registered queries, visit marking and staged visited clear
module maze_map #(
    parameter int COORD_W = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ldEn,
    input  logic [COORD_W-1:0]     ldRow,
    input  logic [(1<<COORD_W)-1:0] ldData,
    input  logic                   ldDone,
    output logic                   ldErr,
    output logic                   ready,
    input  logic                   qValid,
    input  logic [2*COORD_W-1:0]   qLoc,
    output logic                   rValid,
    output logic                   wall,
    output logic                   visited,
    input  logic                   markEn,
    input  logic [2*COORD_W-1:0]   markLoc,
    input  logic                   clrVis,
    output logic [2*COORD_W:0]     visitCnt
);
    localparam int N = 1 << COORD_W;
    typedef enum logic [1:0] {LOAD, RUN, CLR} state_t;
    state_t state, state_nxt;
    logic [N-1:0] wall_map [N];
    logic [N-1:0] visit_map [N];
    logic [N-1:0] row_mask, mask_nxt;
    logic [COORD_W-1:0] clr_row;
    logic [COORD_W-1:0] q_x, q_y, m_x, m_y;
    logic mark_ok;
    assign q_x = qLoc[2*COORD_W-1:COORD_W];
    assign q_y = qLoc[COORD_W-1:0];
    assign m_x = markLoc[2*COORD_W-1:COORD_W];
    assign m_y = markLoc[COORD_W-1:0];
    assign ready = (state == RUN);
    // walls are never marked, so visitCnt counts only free cells
    assign mark_ok = markEn && !wall_map[m_y][m_x] && !visit_map[m_y][m_x];
    always_comb begin
        mask_nxt = row_mask | (ldEn ? (N'(1) << ldRow) : '0);
        state_nxt = (state == LOAD && ldDone && &mask_nxt) ? RUN :
                    (state == RUN && clrVis) ? CLR :
                    (state == CLR && &clr_row) ? RUN : state;
    end
    always_ff @(posedge clk) begin
        if (rst) state <= LOAD;
        else state <= state_nxt;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                wall_map[i] <= '0;
                visit_map[i] <= '0;
            end
            row_mask <= '0;
            clr_row <= '0;
            rValid <= 1'b0;
            wall <= 1'b0;
            visited <= 1'b0;
            ldErr <= 1'b0;
            visitCnt <= '0;
        end else begin
            rValid <= ready && qValid;
            ldErr <= (state == LOAD) && ldDone && !(&mask_nxt);
            if (state == LOAD && ldEn) begin
                wall_map[ldRow] <= ldData;
                row_mask <= mask_nxt;
            end
            if (ready && qValid) begin
                wall <= wall_map[q_y][q_x];
                visited <= visit_map[q_y][q_x];
            end
            if (ready && mark_ok) begin
                visit_map[m_y][m_x] <= 1'b1;
                visitCnt <= visitCnt + 1'b1;
            end
            if (state == CLR) begin
                visit_map[clr_row] <= '0;
                clr_row <= clr_row + 1'b1;
                if (&clr_row) visitCnt <= '0;
            end
        end
    end
endmodule
